// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC and IF/ID pipeline register for the five-stage MIPS core.
// Resolves decode-stage redirects (one delay slot) and flags misaligned targets.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  mpcf,
  input  logic [2:0]  npc_sel,
  input  logic [31:0] rd1,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_f,
  output logic [31:0] ir_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        adel
);

  localparam logic [1:0] PC_NPC = 2'b01;
  localparam logic [1:0] PC_RD1 = 2'b10;

  localparam logic [2:0] NPC_BEQ = 3'b001;
  localparam logic [2:0] NPC_JAL = 3'b010;
  localparam logic [2:0] NPC_JR  = 3'b011;
  localparam logic [2:0] NPC_J   = 3'b100;

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] ir_d_q, ir_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic        adel_q, adel_d;

  logic [31:0] pc4;
  logic [31:0] beq_target;
  logic [31:0] j_target;
  logic [31:0] target;
  logic        redirect;

  // Targets come from the branch sitting in D, not from the instruction in F.
  always_comb begin
    pc4        = pc_d_q + 32'd4;
    beq_target = pc4 + {{14{ir_d_q[15]}}, ir_d_q[15:0], 2'b00};
    j_target   = {pc4[31:28], ir_d_q[25:0], 2'b00};
  end

  always_comb begin
    redirect = 1'b0;
    target   = pc_f_q + 32'd4;
    if (mpcf == PC_RD1) begin
      redirect = 1'b1;
      target   = rd1;
    end else if (mpcf == PC_NPC) begin
      case (npc_sel)
        NPC_BEQ: begin
          redirect = 1'b1;
          target   = beq_target;
        end
        NPC_JAL, NPC_J: begin
          redirect = 1'b1;
          target   = j_target;
        end
        NPC_JR: begin
          redirect = 1'b1;
          target   = rd1;
        end
        default: begin
          redirect = 1'b0;
          target   = pc_f_q + 32'd4;
        end
      endcase
    end
  end

  // A stalled edge holds everything, which also drops the redirect until decode re-presents it.
  always_comb begin
    pc_f_d = pc_f_q;
    ir_d_d = ir_d_q;
    pc_d_d = pc_d_q;
    adel_d = adel_q;
    if (!stall) begin
      pc_f_d = {target[31:2], 2'b00};
      ir_d_d = imem_rdata;
      pc_d_d = pc_f_q;
      if (redirect && (target[1:0] != 2'b00)) begin
        adel_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_f_q <= RESET_PC;
      ir_d_q <= NOP_WORD;
      pc_d_q <= RESET_PC - 32'd4;
      adel_q <= 1'b0;
    end else begin
      pc_f_q <= pc_f_d;
      ir_d_q <= ir_d_d;
      pc_d_q <= pc_d_d;
      adel_q <= adel_d;
    end
  end

  assign pc_f      = pc_f_q;
  assign imem_addr = pc_f_q;
  assign ir_d      = ir_d_q;
  assign pc_d      = pc_d_q;
  assign pc8_d     = pc_d_q + 32'd8;
  assign adel      = adel_q;

endmodule
